// File: rtl/dma_priority_arbiter_if.sv
// Request/grant signal bundle between the DMA timing control and the priority arbiter.
// master: controller side driving requests/configuration; slave: the arbiter.
interface dma_priority_arbiter_if;
    logic [3:0] DREQ;
    logic       HLDA;
    logic [3:0] maskReg;
    logic [3:0] softwareReq;
    logic       controllerDisable;
    logic       priorityType;
    logic       dreqSense;
    logic       dackSense;
    logic       cycleDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantChannel;
    logic [7:0] priorityOrder;

    modport master (
        output DREQ, HLDA, maskReg, softwareReq, controllerDisable,
               priorityType, dreqSense, dackSense, cycleDone,
        input  HRQ, DACK, grantValid, grantChannel, priorityOrder
    );

    modport slave (
        input  DREQ, HLDA, maskReg, softwareReq, controllerDisable,
               priorityType, dreqSense, dackSense, cycleDone,
        output HRQ, DACK, grantValid, grantChannel, priorityOrder
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 4-channel DMA request arbiter: request qualification, HRQ/HLDA handshake, fixed or rotating priority.
// Rotating priority is built only when ROTATING_PRIORITY_EN is defined; otherwise the order is fixed.
module dma_priority_arbiter (
    input  logic                         CLK,
    input  logic                         RESET,
    dma_priority_arbiter_if.slave        bus
);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        REQ     = 4'b0010,
        GRANT   = 4'b0100,
        RELEASE = 4'b1000
    } state_e;

    localparam logic [7:0] DEFAULT_ORDER = 8'b11_10_01_00;

    state_e     state_q, state_d;
    logic [3:0] dreq_q;
    logic       hrq_q, hrq_d;
    logic       gv_q, gv_d;
    logic [1:0] gch_q, gch_d;
    logic [3:0] dack_q, dack_d;
    logic [7:0] order_q, order_d;
    logic [3:0] eff_req;
    logic [1:0] winner;
    logic       winner_found;

`ifdef ROTATING_PRIORITY_EN
    // Channel c just served drops to lowest; c+1 becomes highest.
    function automatic logic [7:0] rotate_order(input logic [1:0] c);
        return {c, c + 2'd3, c + 2'd2, c + 2'd1};
    endfunction
`else
    logic unused_priority_type;
    assign unused_priority_type = bus.priorityType;
`endif

    always_comb begin
        eff_req = (dreq_q | bus.softwareReq) & ~bus.maskReg;
        if (bus.controllerDisable) begin
            eff_req = '0;
        end
    end

    // Scan priorityOrder from the highest field down for the first live request.
    always_comb begin
        winner       = order_q[1:0];
        winner_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!winner_found && eff_req[order_q[2*i +: 2]]) begin
                winner       = order_q[2*i +: 2];
                winner_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hrq_d   = hrq_q;
        gv_d    = gv_q;
        gch_d   = gch_q;
        order_d = order_q;
        unique case (state_q)
            IDLE: begin
                if (|eff_req) begin
                    state_d = REQ;
                    hrq_d   = 1'b1;
                end
            end
            REQ: begin
                if (!(|eff_req)) begin
                    state_d = IDLE;
                    hrq_d   = 1'b0;
                end else if (bus.HLDA) begin
                    state_d = GRANT;
                    gv_d    = 1'b1;
                    gch_d   = winner;
                end
            end
            GRANT: begin
                // cycleDone wins over a simultaneous HLDA drop so the finished transfer still rotates.
                if (bus.cycleDone) begin
                    state_d = RELEASE;
                    hrq_d   = 1'b0;
                    gv_d    = 1'b0;
`ifdef ROTATING_PRIORITY_EN
                    if (bus.priorityType) begin
                        order_d = rotate_order(gch_q);
                    end
`endif
                end else if (!bus.HLDA) begin
                    state_d = IDLE;
                    hrq_d   = 1'b0;
                    gv_d    = 1'b0;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                hrq_d   = 1'b0;
                gv_d    = 1'b0;
            end
        endcase
`ifdef ROTATING_PRIORITY_EN
        if (!bus.priorityType) begin
            order_d = DEFAULT_ORDER;
        end
`else
        order_d = DEFAULT_ORDER;
`endif
        dack_d = ({4{gv_d}} & (4'b0001 << gch_d)) ^ {4{bus.dackSense}};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            dreq_q  <= '0;
            hrq_q   <= 1'b0;
            gv_q    <= 1'b0;
            gch_q   <= '0;
            dack_q  <= '0;
            order_q <= DEFAULT_ORDER;
        end else begin
            state_q <= state_d;
            dreq_q  <= bus.DREQ ^ {4{bus.dreqSense}};
            hrq_q   <= hrq_d;
            gv_q    <= gv_d;
            gch_q   <= gch_d;
            dack_q  <= dack_d;
            order_q <= order_d;
        end
    end

    assign bus.HRQ           = hrq_q;
    assign bus.DACK          = dack_q;
    assign bus.grantValid    = gv_q;
    assign bus.grantChannel  = gch_q;
    assign bus.priorityOrder = order_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Scoreboarded bench for dma_priority_arbiter: directed cases plus randomized grant transactions.
// Expected grants are queued by the driver and matched by a monitor on each rising grantValid.
module tb_dma_priority_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_priority_arbiter_if bus_if ();

    dma_priority_arbiter dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] dack;
    } grant_t;

    grant_t exp_q[$];
    int     prio[4];   // channel numbers, highest priority first
    logic   gv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) prio[i] = i;
    endfunction

    function automatic void model_rotate(input int c);
        for (int i = 0; i < 4; i++) prio[i] = (c + 1 + i) % 4;
    endfunction

    function automatic logic [7:0] model_order();
        logic [7:0] o;
        int         v;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            v = prio[i];
            o[2*i +: 2] = v[1:0];
        end
        return o;
    endfunction

    function automatic int model_winner(input logic [3:0] eff);
        for (int i = 0; i < 4; i++) begin
            if (eff[prio[i]]) return prio[i];
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        grant_t e;
        if (bus_if.grantValid === 1'b1 && !gv_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got channel %0d expected no grant", bus_if.grantChannel);
            end else begin
                e = exp_q.pop_front();
                check("grant_channel", bus_if.grantChannel, e.ch);
                check("grant_dack", bus_if.DACK, e.dack);
            end
        end
        gv_prev <= (bus_if.grantValid === 1'b1);
    end

    task automatic do_grant(input logic [3:0] act, input logic [3:0] mask, input logic [3:0] sw,
                            input logic ds, input logic ks, input logic pt,
                            input logic complete, input logic same_edge);
        logic [3:0] eff;
        logic [3:0] exp_dack;
        logic [1:0] wch;
        int         w;
        int         n;
        grant_t     g;
        bus_if.dreqSense    = ds;
        bus_if.dackSense    = ks;
        bus_if.priorityType = pt;
        bus_if.maskReg      = mask;
        bus_if.softwareReq  = '0;
        bus_if.DREQ         = {4{ds}};
        bus_if.HLDA         = 1'b0;
        bus_if.cycleDone    = 1'b0;
`ifdef ROTATING_PRIORITY_EN
        if (!pt) model_reset();
`endif
        repeat (3) tick();
        check("idle_hrq", bus_if.HRQ, 0);
        check("idle_dack", bus_if.DACK, {4{ks}});
        check("idle_order", bus_if.priorityOrder, model_order());
        eff = (act | sw) & ~mask;
        if (eff == 4'b0000) begin
            bus_if.DREQ        = act ^ {4{ds}};
            bus_if.softwareReq = sw;
            repeat (4) tick();
            check("masked_hrq", bus_if.HRQ, 0);
            check("masked_gv", bus_if.grantValid, 0);
            bus_if.DREQ        = {4{ds}};
            bus_if.softwareReq = '0;
            repeat (3) tick();
        end else begin
            w        = model_winner(eff);
            wch      = w[1:0];
            exp_dack = (4'b0001 << wch) ^ {4{ks}};
            g.ch     = wch;
            g.dack   = exp_dack;
            exp_q.push_back(g);
            bus_if.DREQ        = act ^ {4{ds}};
            bus_if.softwareReq = sw;
            n = 0;
            do begin
                tick();
                n++;
            end while (bus_if.HRQ !== 1'b1 && n < 8);
            check("hrq_latency", n, ((sw & ~mask) != 4'b0000) ? 1 : 2);
            bus_if.HLDA = 1'b1;
            n = 0;
            do begin
                tick();
                n++;
            end while (bus_if.grantValid !== 1'b1 && n < 8);
            check("grant_latency", n, 1);
            check("grant_hrq", bus_if.HRQ, 1);
            bus_if.maskReg = mask | (4'b0001 << wch);
            bus_if.DREQ    = 4'($urandom_range(0, 15));
            repeat (2) tick();
            check("hold_dack", bus_if.DACK, exp_dack);
            check("hold_channel", bus_if.grantChannel, wch);
            check("hold_gv", bus_if.grantValid, 1);
            if (complete) begin
                bus_if.maskReg   = mask;
                bus_if.DREQ      = act ^ {4{ds}};
                bus_if.cycleDone = 1'b1;
                if (same_edge) bus_if.HLDA = 1'b0;
                tick();
                bus_if.cycleDone = 1'b0;
                bus_if.HLDA      = 1'b0;
`ifdef ROTATING_PRIORITY_EN
                if (pt) model_rotate(w);
`endif
                check("release_hrq", bus_if.HRQ, 0);
                check("release_gv", bus_if.grantValid, 0);
                check("release_dack", bus_if.DACK, {4{ks}});
                check("release_order", bus_if.priorityOrder, model_order());
                tick();
                check("rearm_k1_hrq", bus_if.HRQ, 0);
                tick();
                check("rearm_k2_hrq", bus_if.HRQ, 1);
                bus_if.DREQ        = {4{ds}};
                bus_if.softwareReq = '0;
                repeat (4) tick();
                check("drop_hrq", bus_if.HRQ, 0);
            end else begin
                bus_if.HLDA        = 1'b0;
                bus_if.DREQ        = {4{ds}};
                bus_if.softwareReq = '0;
                bus_if.maskReg     = mask;
                tick();
                check("abort_hrq", bus_if.HRQ, 0);
                check("abort_gv", bus_if.grantValid, 0);
                check("abort_dack", bus_if.DACK, {4{ks}});
                check("abort_order", bus_if.priorityOrder, model_order());
                repeat (3) tick();
                check("abort_idle_hrq", bus_if.HRQ, 0);
            end
        end
    endtask

    initial begin
        int n;
        grant_t g;
        rst                      = 1'b1;
        bus_if.DREQ              = 4'b1111;
        bus_if.HLDA              = 1'b0;
        bus_if.maskReg           = '0;
        bus_if.softwareReq       = '0;
        bus_if.controllerDisable = 1'b0;
        bus_if.priorityType      = 1'b0;
        bus_if.dreqSense         = 1'b0;
        bus_if.dackSense         = 1'b0;
        bus_if.cycleDone         = 1'b0;
        model_reset();

        repeat (2) tick();
        check("reset_hrq", bus_if.HRQ, 0);
        check("reset_dack", bus_if.DACK, 4'b0000);
        check("reset_order", bus_if.priorityOrder, 8'hE4);
        check("reset_gv", bus_if.grantValid, 0);
        check("reset_channel", bus_if.grantChannel, 0);
        rst = 1'b0;
        tick();
        check("post_reset_hrq", bus_if.HRQ, 0);
        tick();
        check("post_reset_hrq_rise", bus_if.HRQ, 1);
        bus_if.DREQ = '0;
        repeat (4) tick();
        check("post_reset_drop", bus_if.HRQ, 0);

        do_grant(4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_grant(4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_grant(4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        do_grant(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        bus_if.controllerDisable = 1'b1;
        bus_if.DREQ              = 4'b0100;
        repeat (4) tick();
        check("disable_hrq", bus_if.HRQ, 0);
        bus_if.DREQ              = '0;
        bus_if.controllerDisable = 1'b0;
        repeat (3) tick();

        do_grant(4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_grant(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_grant(4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_grant(4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_grant(4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset arriving while a grant is held
        bus_if.dreqSense    = 1'b0;
        bus_if.dackSense    = 1'b1;
        bus_if.priorityType = 1'b0;
        bus_if.maskReg      = '0;
        model_reset();
        repeat (2) tick();
        g.ch   = 2'd0;
        g.dack = 4'b1110;
        exp_q.push_back(g);
        bus_if.DREQ = 4'b0001;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus_if.HRQ !== 1'b1 && n < 8);
        check("midreset_hrq_latency", n, 2);
        bus_if.HLDA = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus_if.grantValid !== 1'b1 && n < 8);
        check("midreset_grant_latency", n, 1);
        rst = 1'b1;
        tick();
        check("midreset_hrq", bus_if.HRQ, 0);
        check("midreset_dack", bus_if.DACK, 4'b0000);
        check("midreset_gv", bus_if.grantValid, 0);
        check("midreset_order", bus_if.priorityOrder, 8'hE4);
        rst         = 1'b0;
        bus_if.HLDA = 1'b0;
        bus_if.DREQ = '0;
        repeat (4) tick();
        check("after_midreset_dack", bus_if.DACK, 4'b1111);
        check("after_midreset_hrq", bus_if.HRQ, 0);

        for (int t = 0; t < 40; t++) begin
            logic [3:0] a, m, s;
            a = 4'($urandom_range(0, 15));
            m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            do_grant(a, m, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)));
        end

        repeat (5) tick();
        check("pending_grants", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Request arbitration stage of the 4-channel DMA controller, sitting between the DREQ pins and the timing-control state machine. Synchronises and qualifies channel requests, raises HRQ to the CPU, selects the winning channel on HLDA under fixed or rotating priority, and drives DACK plus the grant to timing control. DACK outputs and the priorityOrder register are observed directly by the controller's assertion checker.

## Interface
- No parameters (channel count fixed at 4).
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- DREQ  in  4  channel DMA requests, polarity set by dreqSense.
- HLDA  in  1  hold acknowledge from CPU.
- maskReg  in  4  per-channel mask; 1 = channel ignored.
- softwareReq  in  4  software request bits, always active-high, still subject to maskReg.
- controllerDisable  in  1  commandReg bit; 1 = no new requests honoured.
- priorityType  in  1  commandReg bit; 0 = fixed, 1 = rotating.
- dreqSense  in  1  0 = DREQ active-high, 1 = active-low.
- dackSense  in  1  0 = DACK active-high, 1 = active-low.
- cycleDone  in  1  one-cycle pulse from timing control at end of transfer cycle (S4).
- HRQ  out  1  hold request to CPU.
- DACK  out  4  one-hot channel acknowledge, polarity per dackSense.
- grantValid  out  1  a channel is granted.
- grantChannel  out  2  granted channel index.
- priorityOrder  out  8  four 2-bit channel fields, [1:0] highest priority.

## Operation
- dreqQ <= DREQ ^ {4{dreqSense}} each cycle; effReq = (dreqQ | softwareReq) & ~maskReg, forced 0 when controllerDisable.
- States: IDLE, REQ, GRANT, RELEASE (one-hot).
- IDLE: |effReq -> REQ, HRQ=1. Else stay.
- REQ: HLDA=1 and |effReq -> GRANT; winner = first channel in priorityOrder with effReq set; latch grantChannel, assert grantValid and DACK. effReq==0 before HLDA -> IDLE, HRQ=0.
- GRANT: hold HRQ, DACK, grantChannel. Requests changing mid-grant ignored. cycleDone -> RELEASE. HLDA falling -> IDLE (abort), no rotation.
- RELEASE: HRQ=0, DACK inactive, grantValid=0 for exactly one cycle -> IDLE. Rotation applied on entry.
- Rotation (priorityType=1): after cycleDone of channel c, priorityOrder = {c, c+3, c+2, c+1} (mod 4), i.e. c lowest, c+1 highest.
- Fixed (priorityType=0): priorityOrder = 8'b11_10_01_00; writing priorityType 1->0 reloads default on next edge.
- DACK driven value = ({4{grantValid}} & onehot(grantChannel)) ^ {4{dackSense}}.

## Timing
- Reset (RESET sampled high): state IDLE, HRQ=0, grantValid=0, grantChannel=0, DACK=4'b0000 (dackSense low after reset), priorityOrder=8'b11_10_01_00, dreqQ=0. Reset mid-grant takes effect at the same edge, overriding all.
- DREQ asserted before edge N -> dreqQ at N -> HRQ high after edge N+1 (2-cycle latency). softwareReq: 1 cycle.
- HLDA sampled high in REQ at edge M -> DACK, grantValid, grantChannel valid after edge M.
- cycleDone at edge K -> RELEASE after K, DACK/HRQ low; new HRQ earliest after K+2.
- cycleDone and HLDA fall at same edge: treated as cycleDone (rotation applied), RELEASE entered.
- Mask set on granted channel during GRANT: no effect until RELEASE.
- All outputs registered; no combinational path input to output.

## Configuration
- ROTATING_PRIORITY_EN defined: rotating priority as above when priorityType=1.
- Undefined: priorityType ignored, priorityOrder constant 8'b11_10_01_00, rotation logic absent.

## Test plan
- Reset: RESET high 2 cycles with DREQ=4'b1111 -> HRQ=0, DACK=4'b0000, priorityOrder=8'hE4 after release.
- Fixed priority: DREQ=4'b0110, HLDA high on REQ -> DACK=4'b0010, grantChannel=1; HRQ high 2 cycles after DREQ.
- Rotation (macro on, priorityType=1): DREQ=4'b1001, grant ch0, cycleDone -> priorityOrder=8'b00_11_10_01; next grant DACK=4'b1000.
- Masking/disable: DREQ=4'b0001, maskReg=4'b0001 -> HRQ stays 0; controllerDisable=1 with DREQ=4'b0100 -> HRQ stays 0.
- Abort: grant ch2, drop HLDA without cycleDone -> next cycle DACK=0, HRQ=0, priorityOrder unchanged.
- Sense bits: dreqSense=1, dackSense=1, DREQ=4'b1101 -> grant ch1, DACK=4'b1101; idle DACK=4'b1111.
